// File: rtl/regfile_sb.sv
// regfile_sb: parametrised nR1W register file with preload reset, write-through forwarding
// and a per-register busy scoreboard for read-after-write hazard detection.
module regfile_sb #(
    parameter int DATA_W   = 64,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 31
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREAD*ADDR_W-1:0]   ra,
    output logic [NREAD*DATA_W-1:0]   rd,
    output logic [NREAD-1:0]          rbusy,
    output logic                      stall,
    input  logic                      we3,
    input  logic [ADDR_W-1:0]         wa3,
    input  logic [DATA_W-1:0]         wd3,
    input  logic                      issue_en,
    input  logic [ADDR_W-1:0]         issue_wa,
    output logic [ADDR_W:0]           busy_cnt
);
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W:0]   NR = (ADDR_W+1)'(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
    logic              wr_ok, is_ok;

    assign wr_ok = we3 && wa3 != ZR && {1'b0, wa3} < NR && !reset;
    assign is_ok = issue_en && issue_wa != ZR && {1'b0, issue_wa} < NR && !reset;

    // Issue is applied after the write clear so a same-register issue (newer producer) wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[wa3] = wd3;
            busy_d[wa3] = 1'b0;
        end
        if (is_ok) busy_d[issue_wa] = 1'b1;
        busy_cnt_d = '0;
        for (int i = 0; i < NREGS; i++) busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == ZERO_REG) ? '0 : DATA_W'(i);
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              ok, fwd;
        assign a   = ra[k*ADDR_W +: ADDR_W];
        assign ok  = a != ZR && {1'b0, a} < NR;
        assign fwd = wr_ok && wa3 == a;
        assign rd[k*DATA_W +: DATA_W] = !ok ? '0 : fwd ? wd3 : regs_q[a];
        assign rbusy[k] = ok && busy_q[a] && !fwd;
    end

    assign stall    = |rbusy;
    assign busy_cnt = busy_cnt_q;
endmodule
